// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the async-FIFO write-port arbiter.
// fifo_data layout: {src_id, last, payload}, payload in the LSBs.
package fifo_wr_arb_pkg;

  localparam int DEFAULT_MAX_BURST = 8;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  typedef enum logic [1:0] {
    FLD_PAYLOAD_LSB,
    FLD_LAST_BIT,
    FLD_SRC_MSB
  } fifo_field_e;

  // Bit position of a fifo_data field for a given payload and ID width.
  function automatic int fifo_field_pos(input fifo_field_e field,
                                        input int          data_size,
                                        input int          id_w);
    case (field)
      FLD_PAYLOAD_LSB: return 0;
      FLD_LAST_BIT:    return data_size;
      FLD_SRC_MSB:     return data_size + id_w;
      default:         return 0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first valid requester after last_gnt,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_gnt,
  output logic               any,
  output logic [ID_W-1:0]    pick_id
);

  logic [ID_W-1:0] idx;

  // NOTE: every variable gets a default before any conditional assignment so
  // no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    any     = |req_valid;
    pick_id = '0;
    idx     = '0;
    // Walk from the farthest offset to the nearest so the nearest valid
    // requester is written last and wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = ID_W'((int'(last_gnt) + off) % NUM_REQ);
      if (req_valid[idx]) pick_id = idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ
// requesters. Optional per-requester beat counters: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_SIZE = 32,
  parameter  int MAX_BURST = DEFAULT_MAX_BURST,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int FIFO_W    = DATA_SIZE + ID_W + 1
) (
  input  logic                         clk_wrd,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_push,
  output logic [FIFO_W-1:0]            fifo_data,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic [ID_W-1:0]              stat_sel,
  input  logic                         stat_clr,
  output logic [15:0]                  stat_beats,
`endif
  output logic                         busy
);

  localparam int CNT_W       = $clog2(MAX_BURST + 1);
  localparam int PAYLOAD_LSB = fifo_field_pos(FLD_PAYLOAD_LSB, DATA_SIZE, ID_W);
  localparam int LAST_BIT    = fifo_field_pos(FLD_LAST_BIT, DATA_SIZE, ID_W);
  localparam int SRC_MSB     = fifo_field_pos(FLD_SRC_MSB, DATA_SIZE, ID_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state, state_nxt;
  logic [ID_W-1:0]  grant_id, grant_id_nxt;
  logic [ID_W-1:0]  last_gnt, last_gnt_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic                 any_valid;
  logic [ID_W-1:0]      pick_id;
  logic [DATA_SIZE-1:0] grant_data;
  logic                 eff_last;
  logic                 xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .last_gnt  (last_gnt),
    .any       (any_valid),
    .pick_id   (pick_id)
  );

  // Constant-index mux keeps the payload select free of wide index arithmetic.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) grant_data = req_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id;
    last_gnt_nxt = last_gnt;
    beat_cnt_nxt = beat_cnt;
    req_ready    = '0;
    fifo_push    = 1'b0;
    fifo_data    = '0;
    busy         = 1'b0;
    xfer         = 1'b0;
    eff_last     = req_last[grant_id] | (beat_cnt == LAST_BEAT);

    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_id_nxt = pick_id;
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        busy                = 1'b1;
        req_ready[grant_id] = ~fifo_full;
        xfer                = req_valid[grant_id] & ~fifo_full;
        if (xfer) begin
          fifo_push                                = 1'b1;
          fifo_data[PAYLOAD_LSB +: DATA_SIZE]      = grant_data;
          fifo_data[LAST_BIT]                      = eff_last;
          fifo_data[SRC_MSB -: ID_W]               = grant_id;
          beat_cnt_nxt                             = beat_cnt + 1'b1;
          // A forced release at MAX_BURST looks exactly like a requester last.
          if (eff_last) begin
            last_gnt_nxt = grant_id;
            state_nxt    = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_wrd or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last_gnt <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_id_nxt;
      last_gnt <= last_gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  // NOTE: this counter array is reset explicitly because software reads it
  // directly; arrays with no observable reset value are normally left unreset.
  always_ff @(posedge clk_wrd or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
      stat_beats <= '0;
    end else begin
      if (stat_clr) begin
        for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
      end else if (xfer && (stat_cnt[grant_id] != 16'hFFFF)) begin
        stat_cnt[grant_id] <= stat_cnt[grant_id] + 16'd1;
      end
      stat_beats <= (int'(stat_sel) < NUM_REQ) ? stat_cnt[stat_sel] : 16'd0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: transaction-level model checked
// every cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int IW = 2;
  localparam int FW = DW + IW + 1;

  logic            clk_wrd = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic            fifo_full, fifo_push, busy;
  logic [FW-1:0]   fifo_data;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [IW-1:0]   stat_sel;
  logic            stat_clr;
  logic [15:0]     stat_beats;
`endif

  always #5 clk_wrd = ~clk_wrd;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .clk_wrd   (clk_wrd),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
`ifdef FIFO_WR_ARB_STATS_EN
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_beats(stat_beats),
`endif
    .busy      (busy)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Per-requester beat scripts
  logic [DW-1:0] st_d [N][64];
  logic          st_l [N][64];
  int            head [N];
  int            tail [N];
  logic [N-1:0]  acc;

  typedef struct {
    logic [FW-1:0] data;
    int            cyc;
  } push_t;
  push_t push_log[$];

  // Model: who owns the port (-1 = nobody), beats sent in this grant,
  // and who was served most recently.
  int m_owner = -1;
  int m_beats = 0;
  int m_prev  = N - 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk_wrd) cyc <= cyc + 1;

  always @(posedge clk_wrd or negedge rst) begin
    if (!rst) begin
      m_owner <= -1;
      m_beats <= 0;
      m_prev  <= N - 1;
    end else if (m_owner < 0) begin
      int  winner;
      bit  found;
      winner = 0;
      found  = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req_valid[(m_prev + k) % N]) begin
          winner = (m_prev + k) % N;
          found  = 1;
        end
      end
      if (found) begin
        m_owner <= winner;
        m_beats <= 0;
      end
    end else if (req_valid[m_owner] && !fifo_full) begin
      if (req_last[m_owner] || m_beats + 1 == MB) begin
        m_prev  <= m_owner;
        m_owner <= -1;
      end
      m_beats <= m_beats + 1;
    end
  end

  always @(negedge clk_wrd) begin
    logic [N-1:0]  e_ready;
    logic          e_push, e_busy, e_last;
    logic [FW-1:0] e_data;
    e_ready = '0;
    e_push  = 1'b0;
    e_busy  = 1'b0;
    e_last  = 1'b0;
    e_data  = '0;
    if (rst && m_owner >= 0) begin
      e_busy           = 1'b1;
      e_ready[m_owner] = ~fifo_full;
      e_push           = req_valid[m_owner] & ~fifo_full;
      e_last           = req_last[m_owner] || (m_beats == MB - 1);
      if (e_push) e_data = {IW'(m_owner), e_last, req_data[m_owner*DW +: DW]};
    end
    check("cyc_ready", 64'(req_ready), 64'(e_ready));
    check("cyc_push",  64'(fifo_push), 64'(e_push));
    check("cyc_data",  64'(fifo_data), 64'(e_data));
    check("cyc_busy",  64'(busy),      64'(e_busy));
    if (fifo_push) push_log.push_back('{fifo_data, cyc});
    acc = req_ready & req_valid;
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]            = 1'b1;
        req_last[i]             = st_l[i][head[i]];
        req_data[i*DW +: DW]    = st_d[i][head[i]];
      end else begin
        req_valid[i]            = 1'b0;
        req_last[i]             = 1'b0;
        req_data[i*DW +: DW]    = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_wrd);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && head[i] < tail[i]) head[i]++;
    acc = '0;
    drive();
  endtask

  task automatic add_burst(input int r, input logic [DW-1:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      st_d[r][tail[r]] = base + DW'(b);
      st_l[r][tail[r]] = (b == n - 1);
      tail[r]++;
    end
  endtask

  task automatic flush(input int r);
    head[r] = 0;
    tail[r] = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) flush(i);
    drive();
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_push",  64'(fifo_push), 64'd0);
    check("rst_data",  64'(fifo_data), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    step();
    step();
    rst = 1'b1;
    push_log.delete();
    step();
  endtask

  task automatic wait_pushes(input string name, input int n, input int budget);
    int c;
    c = 0;
    while (push_log.size() < n && c < budget) begin
      step();
      c++;
    end
    check({name, "_done"}, 64'(push_log.size() >= n), 64'd1);
  endtask

  function automatic int src_of(input logic [FW-1:0] d);
    return int'(d[FW-1 -: IW]);
  endfunction

  initial begin
    int c0, bad;
    logic [23:0] order;
    logic [11:0] lasts;
    int n_before;

    rst       = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    acc       = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    step();

    // Single requester, three beats
    do_reset();
    add_burst(2, 32'hA, 3);
    drive();
    c0 = cyc;
    wait_pushes("single", 3, 20);
    if (push_log.size() >= 3) begin
      check("single_b0", 64'(push_log[0].data), 64'({2'd2, 1'b0, 32'h0000000A}));
      check("single_b1", 64'(push_log[1].data), 64'({2'd2, 1'b0, 32'h0000000B}));
      check("single_b2", 64'(push_log[2].data), 64'({2'd2, 1'b1, 32'h0000000C}));
      check("single_lat",    64'(push_log[0].cyc - c0), 64'd1);
      check("single_consec", 64'(push_log[2].cyc - push_log[0].cyc), 64'd2);
    end
    step();
    step();
    check("single_idle", 64'(busy), 64'd0);

    // Fairness: requesters 0,1,3 each with two 2-beat bursts
    do_reset();
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        add_burst(i, 32'(i * 256), 2);
        add_burst(i, 32'(i * 256 + 2), 2);
      end
    end
    drive();
    wait_pushes("fair", 12, 80);
    order = '0;
    bad   = 0;
    for (int j = 0; j < push_log.size(); j++) begin
      if (push_log[j].data[DW]) begin
        order = {order[19:0], 4'(src_of(push_log[j].data))};
        if (j + 1 < push_log.size() && push_log[j+1].cyc - push_log[j].cyc != 2) bad++;
      end else if (j + 1 < push_log.size()) begin
        if (src_of(push_log[j+1].data) != src_of(push_log[j].data)) bad++;
      end
    end
    check("fair_order", 64'(order), 64'h013013);
    check("fair_gaps",  64'(bad), 64'd0);

    // Forced release after MAX_BURST beats
    do_reset();
    add_burst(1, 32'h1000, 12);
    drive();
    wait_pushes("forced", 12, 60);
    lasts = '0;
    bad   = 0;
    for (int j = 0; j < push_log.size() && j < 12; j++) begin
      lasts[j] = push_log[j].data[DW];
      if (push_log[j].data[DW-1:0] != 32'h1000 + 32'(j) || src_of(push_log[j].data) != 1) bad++;
    end
    check("forced_lasts", 64'(lasts), 64'h880);
    check("forced_order", 64'(bad), 64'd0);
    if (push_log.size() >= 9) check("forced_rearb", 64'(push_log[8].cyc - push_log[7].cyc), 64'd2);
    step();
    step();
    check("forced_total", 64'(push_log.size()), 64'd12);

    // Backpressure: FIFO full for 5 cycles after beat 2
    do_reset();
    add_burst(0, 32'h40, 4);
    drive();
    wait_pushes("bp_pre", 2, 20);
    fifo_full = 1'b1;
    n_before  = push_log.size();
    step();
    check("bp_ready", 64'(req_ready), 64'd0);
    check("bp_busy",  64'(busy), 64'd1);
    repeat (4) step();
    check("bp_nopush", 64'(push_log.size()), 64'(n_before));
    fifo_full = 1'b0;
    wait_pushes("bp_post", 4, 20);
    step();
    step();
    check("bp_total", 64'(push_log.size()), 64'd4);
    bad   = 0;
    for (int j = 0; j < push_log.size(); j++) begin
      if (push_log[j].data !== {2'd0, (j == 3), 32'h40 + 32'(j)}) bad++;
    end
    check("bp_order", 64'(bad), 64'd0);

    // Reset mid-burst, then requester 0 must win over 3
    do_reset();
    add_burst(3, 32'h300, 6);
    drive();
    wait_pushes("mrst_pre", 2, 20);
    rst = 1'b0;
    flush(3);
    drive();
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    repeat (3) step();
    check("mrst_push", 64'(fifo_push), 64'd0);
    add_burst(0, 32'h500, 1);
    add_burst(3, 32'h600, 1);
    drive();
    push_log.delete();
    rst = 1'b1;
    wait_pushes("mrst_post", 2, 20);
    if (push_log.size() >= 2) begin
      check("mrst_first",  64'(push_log[0].data), 64'({2'd0, 1'b1, 32'h500}));
      check("mrst_second", 64'(push_log[1].data), 64'({2'd3, 1'b1, 32'h600}));
    end

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    add_burst(0, 32'h700, 5);
    add_burst(1, 32'h800, 3);
    drive();
    wait_pushes("stats", 8, 40);
    step();
    step();
    stat_sel = 2'd0;
    step();
    step();
    check("stats_r0", 64'(stat_beats), 64'd5);
    stat_sel = 2'd1;
    step();
    step();
    check("stats_r1", 64'(stat_beats), 64'd3);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    step();
    step();
    check("stats_clr1", 64'(stat_beats), 64'd0);
    stat_sel = 2'd0;
    step();
    step();
    check("stats_clr0", 64'(stat_beats), 64'd0);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
